// File: rtl/clk_phase_checker.sv
// Receive-side checker for the two-phase strobe interface: validates ph1/ph2
// alternation, rebuilds the half-rate clock, and reports lock/error status.
module clk_phase_checker #(
  parameter int unsigned MAX_GAP    = 4,
  parameter int unsigned LOCK_PAIRS = 3,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk_in,
  input  logic             reset_n,
  input  logic             ph1_in,
  input  logic             ph2_in,
  input  logic             clr,
  output logic             div_clk,
  output logic             locked,
  output logic             err_overlap,
  output logic             err_order,
  output logic             err_timeout,
  output logic [CNT_W-1:0] pair_cnt
);

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    WAIT_P2 = 2'd1,
    WAIT_P1 = 2'd2
  } state_t;

  state_t     state, state_nxt;
  logic [7:0] gap_cnt, gap_nxt;
  logic [7:0] good_cnt, good_nxt;
  logic [8:0] gap_inc;
  logic       div_nxt, lock_nxt;
  logic       set_overlap, set_order, set_timeout;
  logic       pair_done, fault;
  logic       idle, both, p1_only, p2_only;

  assign idle    = ~ph1_in & ~ph2_in;
  assign both    = ph1_in & ph2_in;
  assign p1_only = ph1_in & ~ph2_in;
  assign p2_only = ph2_in & ~ph1_in;
  assign gap_inc = {1'b0, gap_cnt} + 9'd1;

  always_comb begin
    state_nxt   = state;
    div_nxt     = div_clk;
    lock_nxt    = locked;
    gap_nxt     = gap_cnt;
    good_nxt    = good_cnt;
    set_overlap = 1'b0;
    set_order   = 1'b0;
    set_timeout = 1'b0;
    pair_done   = 1'b0;
    fault       = 1'b0;

    unique case (state)
      SEARCH: begin
        gap_nxt = '0;
        if (both) begin
          set_overlap = 1'b1;
        end else if (p1_only) begin
          state_nxt = WAIT_P2;
          div_nxt   = 1'b1;
        end
      end
      WAIT_P2: begin
        if (both) begin
          set_overlap = 1'b1;
          fault       = 1'b1;
        end else if (p1_only) begin
          set_order = 1'b1;
          fault     = 1'b1;
        end else if (p2_only) begin
          state_nxt = WAIT_P1;
          div_nxt   = 1'b0;
          gap_nxt   = '0;
          pair_done = 1'b1;
          if (good_cnt != 8'hFF) good_nxt = good_cnt + 8'd1;
          if (good_nxt >= LOCK_PAIRS[7:0]) lock_nxt = 1'b1;
        end else if (gap_inc == MAX_GAP[8:0]) begin
          set_timeout = 1'b1;
          fault       = 1'b1;
        end else begin
          gap_nxt = gap_inc[7:0];
        end
      end
      WAIT_P1: begin
        if (both) begin
          set_overlap = 1'b1;
          fault       = 1'b1;
        end else if (p2_only) begin
          set_order = 1'b1;
          fault     = 1'b1;
        end else if (p1_only) begin
          state_nxt = WAIT_P2;
          div_nxt   = 1'b1;
          gap_nxt   = '0;
        end else if (gap_inc == MAX_GAP[8:0]) begin
          set_timeout = 1'b1;
          fault       = 1'b1;
        end else begin
          gap_nxt = gap_inc[7:0];
        end
      end
      default: begin
        state_nxt = SEARCH;
        div_nxt   = 1'b0;
        lock_nxt  = 1'b0;
        gap_nxt   = '0;
        good_nxt  = '0;
      end
    endcase

    if (fault) begin
      state_nxt = SEARCH;
      div_nxt   = 1'b0;
      lock_nxt  = 1'b0;
      gap_nxt   = '0;
      good_nxt  = '0;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!reset_n) begin
      state       <= SEARCH;
      div_clk     <= 1'b0;
      locked      <= 1'b0;
      gap_cnt     <= '0;
      good_cnt    <= '0;
      err_overlap <= 1'b0;
      err_order   <= 1'b0;
      err_timeout <= 1'b0;
      pair_cnt    <= '0;
    end else begin
      state       <= state_nxt;
      div_clk     <= div_nxt;
      locked      <= lock_nxt;
      gap_cnt     <= gap_nxt;
      good_cnt    <= good_nxt;
      // a newly detected error wins over a same-cycle clear
      err_overlap <= set_overlap | (err_overlap & ~clr);
      err_order   <= set_order   | (err_order   & ~clr);
      err_timeout <= set_timeout | (err_timeout & ~clr);
      if (pair_done) begin
        if (clr)                pair_cnt <= {{(CNT_W-1){1'b0}}, 1'b1};
        else if (pair_cnt != '1) pair_cnt <= pair_cnt + 1'b1;
      end else if (clr) begin
        pair_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_clk_phase_checker.sv
// Directed bench for clk_phase_checker; a second instance with CNT_W=4
// shares the stimulus to exercise pair counter saturation.
module tb_clk_phase_checker;

  logic        clk_in = 1'b0;
  logic        reset_n;
  logic        ph1_in, ph2_in, clr;
  logic        div_clk, locked, err_overlap, err_order, err_timeout;
  logic [15:0] pair_cnt;
  logic        div_clk4, locked4, err_overlap4, err_order4, err_timeout4;
  logic [3:0]  pair_cnt4;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk_in = ~clk_in;

  clk_phase_checker #(.MAX_GAP(4), .LOCK_PAIRS(3), .CNT_W(16)) dut (
    .clk_in(clk_in), .reset_n(reset_n), .ph1_in(ph1_in), .ph2_in(ph2_in),
    .clr(clr), .div_clk(div_clk), .locked(locked), .err_overlap(err_overlap),
    .err_order(err_order), .err_timeout(err_timeout), .pair_cnt(pair_cnt)
  );

  clk_phase_checker #(.MAX_GAP(4), .LOCK_PAIRS(3), .CNT_W(4)) dut4 (
    .clk_in(clk_in), .reset_n(reset_n), .ph1_in(ph1_in), .ph2_in(ph2_in),
    .clr(clr), .div_clk(div_clk4), .locked(locked4), .err_overlap(err_overlap4),
    .err_order(err_order4), .err_timeout(err_timeout4), .pair_cnt(pair_cnt4)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // drive one cycle of inputs, then sample 1ns after the rising edge
  task automatic step(input logic p1, input logic p2, input logic c);
    ph1_in = p1;
    ph2_in = p2;
    clr    = c;
    @(posedge clk_in);
    #1;
  endtask

  function automatic logic [2:0] errs();
    return {err_overlap, err_order, err_timeout};
  endfunction

  initial begin
    reset_n = 1'b0;
    ph1_in = 1'b1; ph2_in = 1'b1; clr = 1'b0;
    @(negedge clk_in);
    step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    check_val("rst_div", div_clk, 0);
    check_val("rst_lock", locked, 0);
    check_val("rst_errs", errs(), 0);
    check_val("rst_cnt", pair_cnt, 0);
    reset_n = 1'b1;

    // back-to-back alternation, lock after third pair
    for (int unsigned k = 1; k <= 4; k++) begin
      step(1'b1, 1'b0, 1'b0);
      check_val("alt_div_hi", div_clk, 1);
      step(1'b0, 1'b1, 1'b0);
      check_val("alt_div_lo", div_clk, 0);
      check_val("alt_cnt", pair_cnt, k);
      check_val("alt_lock", locked, (k >= 3) ? 1 : 0);
    end
    check_val("alt_errs", errs(), 0);

    // repeated ph1 breaks lock
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    check_val("ord_err", errs(), 3'b010);
    check_val("ord_lock", locked, 0);
    check_val("ord_div", div_clk, 0);
    for (int unsigned k = 1; k <= 3; k++) begin
      step(1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b0);
      check_val("relock_cnt", pair_cnt, 4 + k);
      check_val("relock_lock", locked, (k == 3) ? 1 : 0);
    end
    step(1'b0, 1'b0, 1'b1);
    check_val("clr_errs", errs(), 0);
    check_val("clr_cnt", pair_cnt, 0);
    check_val("clr_lock", locked, 1);

    // gap of 3 idle cycles is tolerated, 4 times out
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0);
    check_val("gap3_errs", errs(), 0);
    check_val("gap3_div", div_clk, 1);
    step(1'b0, 1'b1, 1'b0);
    check_val("gap3_cnt", pair_cnt, 1);
    check_val("gap3_lock", locked, 1);
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0);
    check_val("gap4_pre", errs(), 0);
    step(1'b0, 1'b0, 1'b0);
    check_val("gap4_errs", errs(), 3'b001);
    check_val("gap4_lock", locked, 0);
    check_val("gap4_div", div_clk, 0);

    // overlap in SEARCH, then overlap while locked in WAIT_P1
    step(1'b1, 1'b1, 1'b0);
    check_val("ovs_errs", errs(), 3'b101);
    check_val("ovs_lock", locked, 0);
    step(1'b0, 1'b0, 1'b1);
    check_val("ovs_clr", errs(), 0);
    check_val("ovs_clr_cnt", pair_cnt, 0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b0);
    end
    check_val("ovw_pre_lock", locked, 1);
    step(1'b1, 1'b1, 1'b0);
    check_val("ovw_errs", errs(), 3'b100);
    check_val("ovw_lock", locked, 0);
    check_val("ovw_div", div_clk, 0);

    // clear concurrent with a fresh overlap: set wins
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    check_val("pre_clr_errs", errs(), 3'b110);
    step(1'b1, 1'b1, 1'b1);
    check_val("clrov_errs", errs(), 3'b100);
    check_val("clrov_cnt", pair_cnt, 0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    check_val("clrpair_pre", pair_cnt, 1);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1);
    check_val("clrpair_cnt", pair_cnt, 1);
    check_val("clrpair_errs", errs(), 0);

    // 4-bit counter saturation
    reset_n = 1'b0;
    step(1'b0, 1'b0, 1'b0);
    reset_n = 1'b1;
    for (int unsigned k = 1; k <= 17; k++) begin
      step(1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b0);
      if (k == 15) check_val("sat15_cnt4", pair_cnt4, 15);
    end
    check_val("sat17_cnt4", pair_cnt4, 15);
    check_val("sat17_cnt16", pair_cnt, 17);

    // reset mid-pair, then a leading ph2 is ignored
    step(1'b1, 1'b0, 1'b0);
    check_val("mid_div", div_clk4, 1);
    reset_n = 1'b0;
    step(1'b0, 1'b1, 1'b1);
    reset_n = 1'b1;
    check_val("mrst_div", div_clk4, 0);
    check_val("mrst_lock", locked4, 0);
    check_val("mrst_errs", {err_overlap4, err_order4, err_timeout4}, 0);
    check_val("mrst_cnt", pair_cnt4, 0);
    step(1'b0, 1'b1, 1'b0);
    check_val("lead_p2_cnt", pair_cnt4, 0);
    check_val("lead_p2_errs", {err_overlap4, err_order4, err_timeout4}, 0);
    step(1'b1, 1'b0, 1'b0);
    check_val("post_p1_div", div_clk4, 1);
    step(1'b0, 1'b1, 1'b0);
    check_val("post_pair_cnt", pair_cnt4, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/clk_phase_checker.md
Name: clk_phase_checker

Overview:
- Receive end of the two-phase strobe interface driven by the clock generator block.
- Samples the phase-1 and phase-2 strobes synchronously, checks strict alternation and non-overlap, and rebuilds a half-rate divided clock from accepted pairs.
- Reports lock status, sticky error causes, and a saturating pair count to the status/debug register bank.

Parameters:
- MAX_GAP, 4: consecutive idle cycles (neither strobe high) that trigger a timeout while tracking; legal range 1..255.
- LOCK_PAIRS, 3: consecutive good ph1→ph2 pairs required to assert locked; legal range 1..255.
- CNT_W, 16: width of pair_cnt.

Ports:
- clk_in  input  1  block clock; all logic on its rising edge.
- reset_n  input  1  synchronous active-low reset.
- ph1_in  input  1  phase-1 strobe, synchronous to clk_in.
- ph2_in  input  1  phase-2 strobe, synchronous to clk_in.
- clr  input  1  synchronous clear of sticky errors and pair_cnt.
- div_clk  output  1  reconstructed half-rate clock: high from accepted ph1 to accepted ph2.
- locked  output  1  LOCK_PAIRS consecutive good pairs seen with no error since.
- err_overlap  output  1  sticky: ph1_in and ph2_in high in the same cycle.
- err_order  output  1  sticky: repeated phase (ph1 after ph1, or ph2 after ph2) while tracking.
- err_timeout  output  1  sticky: MAX_GAP idle cycles while tracking.
- pair_cnt  output  CNT_W  saturating count of completed ph1→ph2 pairs.

Behaviour:
- Reset (reset_n=0 at a rising edge): state=SEARCH. div_clk, locked, all err_* = 0. pair_cnt=0. Gap counter and good-pair counter = 0. Reset overrides all other inputs.
- All outputs are registered. Inputs sampled at edge N are reflected in outputs after edge N.
- States:
  - SEARCH: ph1 only → WAIT_P2, div_clk=1. ph2 only is ignored and the block stays in SEARCH. Both high → err_overlap=1, stay. Idle → stay; no timeout in SEARCH.
  - WAIT_P2: ph2 only → WAIT_P1, div_clk=0, pair_cnt+1 (saturating at all-ones), good-pair counter+1 (saturating).
  - WAIT_P1: ph1 only → WAIT_P2, div_clk=1.
- Error transitions (WAIT_P2 or WAIT_P1 only):
  - Repeated phase (ph1 in WAIT_P2, or ph2 in WAIT_P1) → err_order=1, state=SEARCH.
  - Both strobes high → err_overlap=1, state=SEARCH.
  - Any error also sets div_clk=0, locked=0, and good-pair counter=0.
- Gap counter:
  - Cleared on every accepted strobe and on entering SEARCH.
  - Incremented on each idle cycle in WAIT_P2 or WAIT_P1.
  - On the idle cycle where it would reach MAX_GAP: err_timeout=1, state=SEARCH, and the same clears as any other error.
  - Zero idle cycles between strobes (back-to-back alternation every cycle) is legal.
- locked: set on the edge where the good-pair counter reaches LOCK_PAIRS. Stays high until an error or reset; re-entry requires a fresh LOCK_PAIRS.
- Overlap in SEARCH sets err_overlap only; locked is already 0 there.
- clr=1: clears err_overlap, err_order, err_timeout and pair_cnt. It does not affect state, div_clk, or locked.
  - If an error is detected in the same cycle, that error flag is set; set wins over clear.
  - If a pair completes in the same cycle, pair_cnt=1.
- pair_cnt at all-ones stays at all-ones on further pairs.

Test Plan:
- Reset, then ph1,ph2 alternating every cycle for 8 cycles (4 pairs), LOCK_PAIRS=3 → div_clk toggles 1,0,1,0…; locked=1 after the 3rd ph2 edge; pair_cnt=4; no errors.
- Locked, then ph1 twice with no ph2 between → err_order=1, locked=0, div_clk=0, state SEARCH; next ph1,ph2 → pair_cnt increments, locked stays 0 until 3 more pairs.
- In WAIT_P2 with MAX_GAP=4: 3 idle cycles then ph2 → accepted, no error. Repeat with 4 idle cycles → err_timeout=1 on the 4th idle edge.
- ph1_in=ph2_in=1 in SEARCH → err_overlap=1, locked stays 0. Same in WAIT_P1 while locked → err_overlap=1, locked=0.
- Error flags set, clr=1 together with a new overlap → err_overlap=1, other error flags 0, pair_cnt=0. clr=1 on a pair-complete cycle → pair_cnt=1.
- CNT_W=4: 17 pairs → pair_cnt=15. Then reset_n=0 mid-pair (WAIT_P2) for 1 cycle → all outputs 0, state SEARCH; a leading ph2 after reset is ignored.
